// File: rtl/beta_if_id_queue.sv
// ---------------------------------------------------------------------------
// beta_if_id_queue
//
// Instruction queue sitting between the fetch stage and the decode stage.
// Every (PC, instruction) pair that fetch flags as new is captured into a
// small circular FIFO. The oldest pair is presented to decode with a
// valid/ready handshake. Full / almost-full flags let fetch throttle itself,
// and a flush input drops everything when the front end is redirected.
//
// Parameters:
//   DataWidth : width of the PC and instruction words (32 or 64)
//   Depth     : number of queue entries (power of two, >= 2)
//
// Ports:
//   clk_i           clock, all state changes on the rising edge
//   rst_i           asynchronous, active-high reset
//   iq_new_instr_i  fetch delivers a new instruction this cycle
//   iq_pc_i         PC of the delivered instruction
//   iq_instr_i      delivered instruction word
//   iq_flush_i      discard every queued entry (redirect)
//   iq_full_o       queue holds Depth entries
//   iq_afull_o      queue holds at least Depth-1 entries
//   iq_count_o      current occupancy
//   iq_overflow_o   sticky: an instruction arrived while full and was dropped
//   id_ready_i      decode accepts the head entry this cycle
//   id_valid_o      head entry is valid
//   id_pc_o         head PC (0 when empty)
//   id_instr_o      head instruction (NOP when empty)
//   id_illegal_o    head is valid and not a 32-bit encoding
//                   (only present when BETA_IQ_ILLEGAL_CHK_EN is defined)
//
// Optional feature macro: BETA_IQ_ILLEGAL_CHK_EN
// ---------------------------------------------------------------------------
module beta_if_id_queue #(
    parameter int DataWidth = 32,
    parameter int Depth     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   iq_new_instr_i,
    input  logic [DataWidth-1:0]   iq_pc_i,
    input  logic [DataWidth-1:0]   iq_instr_i,
    input  logic                   iq_flush_i,
    output logic                   iq_full_o,
    output logic                   iq_afull_o,
    output logic [$clog2(Depth):0] iq_count_o,
    output logic                   iq_overflow_o,
    input  logic                   id_ready_i,
    output logic                   id_valid_o,
    output logic [DataWidth-1:0]   id_pc_o,
    output logic [DataWidth-1:0]   id_instr_o
`ifdef BETA_IQ_ILLEGAL_CHK_EN
    ,
    output logic                   id_illegal_o
`endif
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    localparam logic [PtrW-1:0]      PtrZero   = '0;
    localparam logic [PtrW-1:0]      PtrOne    = PtrW'(1);
    localparam logic [CntW-1:0]      CntZero   = '0;
    localparam logic [CntW-1:0]      CntOne    = CntW'(1);
    localparam logic [CntW-1:0]      CntFull   = CntW'(Depth);
    localparam logic [CntW-1:0]      CntAfull  = CntW'(Depth - 1);
    localparam logic [DataWidth-1:0] NopInstr  = DataWidth'(32'h0000_0013);

    // Pointer and occupancy state
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q,  count_d;
    logic            overflow_q, overflow_d;

    // Entry storage; contents are deliberately left unreset
    logic [DataWidth-1:0] mem_pc_q    [Depth];
    logic [DataWidth-1:0] mem_instr_q [Depth];

    logic is_full;
    logic is_valid;
    logic push;
    logic pop;

    // Handshake decode. A flush wins over everything: the incoming
    // instruction is on the wrong path and a same-cycle ready is not a
    // consumption. A push into a full queue is allowed only when the head
    // leaves in the same cycle, freeing a slot.
    always_comb begin
        is_full  = (count_q == CntFull);
        is_valid = (count_q != CntZero);
        pop      = is_valid & id_ready_i & ~iq_flush_i;
        push     = iq_new_instr_i & ~iq_flush_i & (~is_full | pop);
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    // Pointers wrap naturally because Depth is a power of two.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (iq_flush_i) begin
            wr_ptr_d = PtrZero;
            rd_ptr_d = PtrZero;
            count_d  = CntZero;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
            // A delivered instruction that could not be stored is lost
            if (iq_new_instr_i && !push) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= PtrZero;
            rd_ptr_q   <= PtrZero;
            count_q    <= CntZero;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry write port; no reset so the array can map onto plain storage
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= iq_pc_i;
            mem_instr_q[wr_ptr_q] <= iq_instr_i;
        end
    end

    // All outputs come from registered state only, so there is no
    // combinational path from the fetch-side inputs to decode.
    always_comb begin
        iq_full_o     = is_full;
        iq_afull_o    = (count_q >= CntAfull) && (count_q != CntZero);
        iq_count_o    = count_q;
        iq_overflow_o = overflow_q;
        id_valid_o    = is_valid;
        id_pc_o       = '0;
        id_instr_o    = NopInstr;
        if (is_valid) begin
            id_pc_o    = mem_pc_q[rd_ptr_q];
            id_instr_o = mem_instr_q[rd_ptr_q];
        end
    end

`ifdef BETA_IQ_ILLEGAL_CHK_EN
    // Only 32-bit encodings (low bits 2'b11) are supported; compressed
    // encodings are flagged for decode.
    always_comb begin
        id_illegal_o = id_valid_o & (id_instr_o[1:0] != 2'b11);
    end
`endif

endmodule
